// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one SRAM-like memory port between the instruction-fetch requester
// (inst_*) and the load/store requester (data_*). The address phase uses a
// req/addr_ok handshake. The data phase uses data_ok, and responses return
// strictly in accept order. An owner FIFO records who issued each accepted
// transaction, so every mem_data_ok can be routed back to that requester.
// Neither path adds any cycles of latency.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   inst_req/wr/size/addr/     instruction requester address phase
//     wstrb/wdata
//   inst_addr_ok/data_ok/rdata instruction requester handshake + read data
//   data_*                     same set for the load/store requester
//   mem_req/wr/size/addr/      downstream request with the granted payload
//     wstrb/wdata
//   mem_addr_ok/data_ok/rdata  downstream handshake + read data
//   outstanding                accepted-but-unanswered transaction count
//   proto_err                  sticky protocol-violation flag
//
// Parameter
//   OUTSTANDING                owner FIFO depth, 1..8
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic [3:0]  outstanding,
  output logic        proto_err
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD_I = 2'd1,
    S_HOLD_D = 2'd2
  } state_t;

  state_t                 r_state;
  logic [OUTSTANDING-1:0] r_owner;     // 1 = data, 0 = inst
  logic [PTR_W-1:0]       r_wptr;
  logic [PTR_W-1:0]       r_rptr;
  logic [3:0]             r_count;
  logic                   r_proto_err;

  logic w_full;
  logic w_empty;
  logic w_grant;
  logic w_sel_data;
  logic w_accept;
  logic w_pop;
  logic w_head;

  // Advance a FIFO pointer, wrapping at the configured depth. The depth
  // need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full  = (r_count == 4'(OUTSTANDING));
  assign w_empty = (r_count == 4'd0);

  // Grant selection. The grant depends only on registered state and the
  // request inputs. It never depends on mem_data_ok, so a pop while full
  // frees a slot for the following cycle only.
  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_grant    = 1'b0;
    w_sel_data = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_full) begin
          if (data_req) begin
            w_grant    = 1'b1;
            w_sel_data = 1'b1;
          end else if (inst_req) begin
            w_grant    = 1'b1;
          end
        end
      end
      // While a request is held, only the held requester is forwarded. This
      // keeps the payload stable until the downstream accepts it.
      S_HOLD_I: begin
        w_grant    = inst_req;
        w_sel_data = 1'b0;
      end
      S_HOLD_D: begin
        w_grant    = data_req;
        w_sel_data = 1'b1;
      end
      default: begin
        w_grant    = 1'b0;
        w_sel_data = 1'b0;
      end
    endcase
  end

  // Downstream request and payload, both combinational from the grant.
  assign mem_req   = w_grant & ~reset;
  assign mem_wr    = w_sel_data ? data_wr    : inst_wr;
  assign mem_size  = w_sel_data ? data_size  : inst_size;
  assign mem_addr  = w_sel_data ? data_addr  : inst_addr;
  assign mem_wstrb = w_sel_data ? data_wstrb : inst_wstrb;
  assign mem_wdata = w_sel_data ? data_wdata : inst_wdata;

  assign w_accept     = mem_req & mem_addr_ok;
  assign inst_addr_ok = w_accept & ~w_sel_data;
  assign data_addr_ok = w_accept &  w_sel_data;

  // A response that arrives with nothing in flight is dropped and flagged.
  // It is never routed to either requester.
  assign w_head       = r_owner[r_rptr];
  assign w_pop        = mem_data_ok & ~w_empty & ~reset;
  assign inst_data_ok = w_pop & ~w_head;
  assign data_data_ok = w_pop &  w_head;

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  assign outstanding = r_count;
  assign proto_err   = r_proto_err;

  // Owner storage. Entries are read only once a matching push has written
  // them, so this storage needs no reset.
  // NOTE: storage arrays are left out of the reset branch on purpose. The
  // count and pointers decide which entries are valid, and resetting the
  // array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_owner[r_wptr] <= w_sel_data;
    end
  end

  // Control state: FSM, FIFO pointers, in-flight count, error flag.
  // NOTE: sequential state uses non-blocking assignments only. Every
  // register then samples the pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= 4'd0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wptr <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end

      // A push and a pop in the same cycle leave the count unchanged.
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase

      if (mem_data_ok && w_empty) begin
        r_proto_err <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_grant && !mem_addr_ok) begin
            r_state <= w_sel_data ? S_HOLD_D : S_HOLD_I;
          end
        end
        S_HOLD_I: begin
          // Dropping req before addr_ok abandons the held request.
          if (!inst_req) begin
            r_proto_err <= 1'b1;
            r_state     <= S_IDLE;
          end else if (mem_addr_ok) begin
            r_state <= S_IDLE;
          end
        end
        S_HOLD_D: begin
          if (!data_req) begin
            r_proto_err <= 1'b1;
            r_state     <= S_IDLE;
          end else if (mem_addr_ok) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int OUT = 2;

  logic        clk;
  logic        reset;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [3:0]  inst_wstrb;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic [3:0]  outstanding;
  logic        proto_err;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.OUTSTANDING(OUT)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .outstanding(outstanding), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1; inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
    total++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin bad++; $display("FAIL rst_addr_ok got=%b exp=00", {inst_addr_ok, data_addr_ok}); end
    total++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin bad++; $display("FAIL rst_data_ok got=%b exp=00", {inst_data_ok, data_data_ok}); end
    @(negedge clk);
    idle_inputs();
    #1;
    total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", outstanding); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL rst_proto_err got=%b exp=0", proto_err); end
    reset = 0;
  endtask

  task automatic test_single_read();
    do_reset();
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1;
    #1;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL single_mem_req got=%b exp=1", mem_req); end
    total++; if (mem_addr !== 32'h1C00_0000) begin bad++; $display("FAIL single_mem_addr got=%h exp=1c000000", mem_addr); end
    total++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin bad++; $display("FAIL single_addr_ok got=%b exp=10", {inst_addr_ok, data_addr_ok}); end
    @(negedge clk);
    inst_req = 0; mem_addr_ok = 0;
    #1;
    total++; if (outstanding !== 4'd1) begin bad++; $display("FAIL single_count1 got=%0d exp=1", outstanding); end
    @(negedge clk);
    mem_data_ok = 1; mem_rdata = 32'h0280_0C0C;
    #1;
    total++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin bad++; $display("FAIL single_data_ok got=%b exp=10", {inst_data_ok, data_data_ok}); end
    total++; if (inst_rdata !== 32'h0280_0C0C) begin bad++; $display("FAIL single_rdata got=%h exp=02800c0c", inst_rdata); end
    @(negedge clk);
    mem_data_ok = 0;
    #1;
    total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL single_count0 got=%0d exp=0", outstanding); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL single_proto_err got=%b exp=0", proto_err); end
  endtask

  task automatic test_contention();
    do_reset();
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h1C00_0040;
    data_req = 1; data_wr = 1; data_wstrb = 4'hF; data_addr = 32'h1C00_1000; data_wdata = 32'hDEAD_BEEF;
    mem_addr_ok = 1;
    #1;
    total++; if (mem_addr !== 32'h1C00_1000) begin bad++; $display("FAIL cont_first_addr got=%h exp=1c001000", mem_addr); end
    total++; if ({mem_wr, mem_wstrb} !== 5'b1_1111) begin bad++; $display("FAIL cont_first_wr got=%b exp=11111", {mem_wr, mem_wstrb}); end
    total++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin bad++; $display("FAIL cont_first_ok got=%b exp=01", {inst_addr_ok, data_addr_ok}); end
    @(negedge clk);
    data_req = 0;
    #1;
    total++; if (mem_addr !== 32'h1C00_0040) begin bad++; $display("FAIL cont_second_addr got=%h exp=1c000040", mem_addr); end
    total++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin bad++; $display("FAIL cont_second_ok got=%b exp=10", {inst_addr_ok, data_addr_ok}); end
    @(negedge clk);
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #1;
    total++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin bad++; $display("FAIL cont_resp1 got=%b exp=01", {inst_data_ok, data_data_ok}); end
    @(negedge clk);
    #1;
    total++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin bad++; $display("FAIL cont_resp2 got=%b exp=10", {inst_data_ok, data_data_ok}); end
    @(negedge clk);
    mem_data_ok = 0;
    #1;
    total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL cont_count got=%0d exp=0", outstanding); end
  endtask

  task automatic test_hold();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      inst_req = 1; inst_addr = 32'h1C00_0100;
      if (c == 1) begin data_req = 1; data_addr = 32'h1C00_2000; end
      #1;
      total++; if (mem_addr !== 32'h1C00_0100) begin bad++; $display("FAIL hold_addr_c%0d got=%h exp=1c000100", c, mem_addr); end
      total++; if ({mem_req, inst_addr_ok, data_addr_ok} !== 3'b100) begin bad++; $display("FAIL hold_req_c%0d got=%b exp=100", c, {mem_req, inst_addr_ok, data_addr_ok}); end
    end
    @(negedge clk);
    mem_addr_ok = 1;
    #1;
    total++; if (mem_addr !== 32'h1C00_0100) begin bad++; $display("FAIL hold_accept_addr got=%h exp=1c000100", mem_addr); end
    total++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin bad++; $display("FAIL hold_accept_ok got=%b exp=10", {inst_addr_ok, data_addr_ok}); end
    @(negedge clk);
    inst_req = 0;
    #1;
    total++; if (mem_addr !== 32'h1C00_2000) begin bad++; $display("FAIL hold_next_addr got=%h exp=1c002000", mem_addr); end
    total++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin bad++; $display("FAIL hold_next_ok got=%b exp=01", {inst_addr_ok, data_addr_ok}); end
    @(negedge clk);
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #1;
    total++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin bad++; $display("FAIL hold_resp1 got=%b exp=10", {inst_data_ok, data_data_ok}); end
    @(negedge clk);
    #1;
    total++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin bad++; $display("FAIL hold_resp2 got=%b exp=01", {inst_data_ok, data_data_ok}); end
    @(negedge clk);
    mem_data_ok = 0;
  endtask

  task automatic test_full();
    do_reset();
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h1C00_0200; mem_addr_ok = 1;
    @(negedge clk);
    inst_addr = 32'h1C00_0204;
    #1;
    total++; if (outstanding !== 4'd1) begin bad++; $display("FAIL full_count1 got=%0d exp=1", outstanding); end
    @(negedge clk);
    inst_req = 0; data_req = 1; data_addr = 32'h1C00_3000;
    #1;
    total++; if (outstanding !== 4'd2) begin bad++; $display("FAIL full_count2 got=%0d exp=2", outstanding); end
    total++; if ({mem_req, data_addr_ok} !== 2'b00) begin bad++; $display("FAIL full_blocked got=%b exp=00", {mem_req, data_addr_ok}); end
    @(negedge clk);
    mem_data_ok = 1;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL full_pop_same_cycle got=%b exp=0", mem_req); end
    total++; if (inst_data_ok !== 1'b1) begin bad++; $display("FAIL full_pop_route got=%b exp=1", inst_data_ok); end
    @(negedge clk);
    mem_data_ok = 0;
    #1;
    total++; if (outstanding !== 4'd1) begin bad++; $display("FAIL full_after_pop got=%0d exp=1", outstanding); end
    total++; if ({mem_req, data_addr_ok} !== 2'b11) begin bad++; $display("FAIL full_regrant got=%b exp=11", {mem_req, data_addr_ok}); end
    @(negedge clk);
    data_req = 0; mem_addr_ok = 0;
    #1;
    total++; if (outstanding !== 4'd2) begin bad++; $display("FAIL full_refill got=%0d exp=2", outstanding); end
    @(negedge clk);
    mem_data_ok = 1;
    #1;
    total++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin bad++; $display("FAIL full_drain1 got=%b exp=10", {inst_data_ok, data_data_ok}); end
    @(negedge clk);
    #1;
    total++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin bad++; $display("FAIL full_drain2 got=%b exp=01", {inst_data_ok, data_data_ok}); end
    @(negedge clk);
    mem_data_ok = 0;
  endtask

  task automatic test_back_to_back();
    logic prev_owner;
    logic cur_owner;
    do_reset();
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h1C00_0300; mem_addr_ok = 1;
    prev_owner = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cur_owner = (k % 2 == 0);
      inst_req = ~cur_owner; data_req = cur_owner;
      inst_addr = 32'h1C00_0400 + 32'(k * 4); data_addr = 32'h1C00_4000 + 32'(k * 4);
      mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = $urandom;
      #1;
      total++; if ({inst_data_ok, data_data_ok} !== {~prev_owner, prev_owner}) begin bad++; $display("FAIL b2b_route_%0d got=%b exp=%b", k, {inst_data_ok, data_data_ok}, {~prev_owner, prev_owner}); end
      total++; if ({inst_addr_ok, data_addr_ok} !== {~cur_owner, cur_owner}) begin bad++; $display("FAIL b2b_accept_%0d got=%b exp=%b", k, {inst_addr_ok, data_addr_ok}, {~cur_owner, cur_owner}); end
      total++; if (outstanding !== 4'd1) begin bad++; $display("FAIL b2b_count_%0d got=%0d exp=1", k, outstanding); end
      prev_owner = cur_owner;
    end
    @(negedge clk);
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #1;
    total++; if ({inst_data_ok, data_data_ok} !== {~prev_owner, prev_owner}) begin bad++; $display("FAIL b2b_last got=%b exp=%b", {inst_data_ok, data_data_ok}, {~prev_owner, prev_owner}); end
    @(negedge clk);
    mem_data_ok = 0;
    #1;
    total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL b2b_drained got=%0d exp=0", outstanding); end
  endtask

  task automatic test_errors();
    do_reset();
    @(negedge clk);
    mem_data_ok = 1;
    #1;
    total++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin bad++; $display("FAIL err_empty_route got=%b exp=00", {inst_data_ok, data_data_ok}); end
    @(negedge clk);
    mem_data_ok = 0;
    #1;
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL err_empty_flag got=%b exp=1", proto_err); end
    total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL err_empty_count got=%0d exp=0", outstanding); end
    inst_req = 1; data_req = 1; mem_addr_ok = 1;
    @(negedge clk);
    @(negedge clk);
    inst_req = 0; data_req = 0; mem_addr_ok = 0;
    #1;
    total++; if (outstanding !== 4'd2) begin bad++; $display("FAIL err_pre_reset got=%0d exp=2", outstanding); end
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL err_reset_count got=%0d exp=0", outstanding); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL err_reset_flag got=%b exp=0", proto_err); end
    @(negedge clk);
    mem_data_ok = 1;
    #1;
    total++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin bad++; $display("FAIL err_stale_route got=%b exp=00", {inst_data_ok, data_data_ok}); end
    @(negedge clk);
    mem_data_ok = 0;
    #1;
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL err_stale_flag got=%b exp=1", proto_err); end
    do_reset();
    @(negedge clk);
    inst_req = 1;
    @(negedge clk);
    inst_req = 0; data_req = 1; data_addr = 32'h1C00_5000;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL err_drop_req got=%b exp=0", mem_req); end
    @(negedge clk);
    data_req = 0;
    #1;
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL err_drop_flag got=%b exp=1", proto_err); end
  endtask

  // Reference model: an ordered queue of owners plus the identity of any
  // requester whose address phase is being held by the downstream.
  task automatic test_random();
    bit          owners[$];
    int          held;          // 0 none, 1 inst, 2 data
    int          grant;         // 0 none, 1 inst, 2 data
    bit          i_pend, d_pend, accept, pop, head;
    logic [31:0] e_addr, e_wdata;
    do_reset();
    held = 0; i_pend = 0; d_pend = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1; inst_addr = $urandom; inst_wdata = $urandom; inst_wr = 1'($urandom);
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; data_addr = $urandom; data_wdata = $urandom; data_wr = 1'($urandom);
      end
      inst_req = i_pend; data_req = d_pend;
      mem_addr_ok = 1'($urandom);
      mem_data_ok = (owners.size() > 0) && ($urandom_range(0, 2) != 0);
      mem_rdata = $urandom;

      if (held == 1)      grant = i_pend ? 1 : 0;
      else if (held == 2) grant = d_pend ? 2 : 0;
      else if (owners.size() >= OUT) grant = 0;
      else grant = d_pend ? 2 : (i_pend ? 1 : 0);
      e_addr  = (grant == 2) ? data_addr  : inst_addr;
      e_wdata = (grant == 2) ? data_wdata : inst_wdata;
      accept  = (grant != 0) && mem_addr_ok;
      pop     = mem_data_ok && (owners.size() > 0);
      head    = pop ? owners[0] : 1'b0;

      #1;
      total++; if (mem_req !== (grant != 0)) begin bad++; $display("FAIL rnd_mem_req n=%0d got=%b exp=%b", n, mem_req, grant != 0); end
      if (grant != 0) begin
        total++; if ({mem_addr, mem_wdata} !== {e_addr, e_wdata}) begin bad++; $display("FAIL rnd_payload n=%0d got=%h_%h exp=%h_%h", n, mem_addr, mem_wdata, e_addr, e_wdata); end
      end
      total++; if ({inst_addr_ok, data_addr_ok} !== {accept && grant == 1, accept && grant == 2}) begin bad++; $display("FAIL rnd_addr_ok n=%0d got=%b exp=%b", n, {inst_addr_ok, data_addr_ok}, {accept && grant == 1, accept && grant == 2}); end
      total++; if ({inst_data_ok, data_data_ok} !== {pop && !head, pop && head}) begin bad++; $display("FAIL rnd_data_ok n=%0d got=%b exp=%b", n, {inst_data_ok, data_data_ok}, {pop && !head, pop && head}); end
      total++; if (data_rdata !== mem_rdata || inst_rdata !== mem_rdata) begin bad++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, data_rdata, mem_rdata); end
      total++; if (outstanding !== 4'(owners.size())) begin bad++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, outstanding, owners.size()); end
      total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL rnd_proto_err n=%0d got=%b exp=0", n, proto_err); end

      if (pop) void'(owners.pop_front());
      if (accept) begin
        owners.push_back(grant == 2);
        if (grant == 2) d_pend = 0; else i_pend = 0;
      end
      if (held == 0 && grant != 0 && !accept) held = grant;
      else if (held != 0 && accept) held = 0;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_hold();
    test_full();
    test_back_to_back();
    test_errors();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
